// File: rtl/ecc_encode_pipe.sv
// Pipelined Hamming SEC encoder (32 data + 6 check bits) behind a 2-entry valid/ready skid buffer.
// Optional build macro ERR_INJECT_EN enables single-bit error injection on the stored codeword.
module ecc_encode_pipe #(
  parameter int DATA_W = 32,
  parameter int PAR_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_parity,
  output logic [CNT_W-1:0]  word_count,
  input  logic              inject_en,
  input  logic [5:0]        inject_pos
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Even parity; masks match the downstream SEC decoder's check-bit coverage.
  function automatic logic [5:0] calc_parity(input logic [31:0] d);
    logic [5:0] p;
    p[0] = ^(d & 32'h56AA_AD5B);
    p[1] = ^(d & 32'h9B33_366D);
    p[2] = ^(d & 32'hE3C3_C78E);
    p[3] = ^(d & 32'h03FC_07F0);
    p[4] = ^(d & 32'h03FF_F800);
    p[5] = ^(d & 32'hFC00_0000);
    return p;
  endfunction

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [PAR_W-1:0]  main_par_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [PAR_W-1:0]  skid_par_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic [DATA_W-1:0] enc_data_s;
  logic [PAR_W-1:0]  enc_par_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready;

`ifdef ERR_INJECT_EN
  logic [37:0] flip_s;

  // Corrupt at most one codeword bit after parity generation; positions 38..63 are no-ops.
  always_comb begin
    flip_s = 38'd0;
    if (inject_en && (inject_pos < 6'd38)) begin
      flip_s = 38'd1 << inject_pos;
    end else begin
      flip_s = 38'd0;
    end
    {enc_par_s, enc_data_s} = {calc_parity(in_data), in_data} ^ flip_s;
  end
`else
  logic unused_inject_s;
  assign unused_inject_s = ^{inject_en, inject_pos};

  // Clean codeword only.
  always_comb begin
    enc_data_s = in_data;
    enc_par_s  = calc_parity(in_data);
  end
`endif

  // Saturating output-transfer counter.
  always_comb begin
    count_d = count_q;
    if (out_fire_s && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Skid-buffer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_data_q <= {DATA_W{1'b0}};
      main_par_q  <= {PAR_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      skid_par_q  <= {PAR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_fire_s) begin
            main_data_q <= enc_data_s;
            main_par_q  <= enc_par_s;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ONE: begin
          case ({in_fire_s, out_fire_s})
            2'b10: begin
              skid_data_q <= enc_data_s;
              skid_par_q  <= enc_par_s;
              in_ready_q  <= 1'b0;
              state_q     <= FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= EMPTY;
            end
            2'b11: begin
              main_data_q <= enc_data_s;
              main_par_q  <= enc_par_s;
            end
            default: begin
              state_q <= ONE;
            end
          endcase
        end
        FULL: begin
          if (out_fire_s) begin
            main_data_q <= skid_data_q;
            main_par_q  <= skid_par_q;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_data_q;
  assign out_parity = main_par_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Scoreboard bench for ecc_encode_pipe; expected codewords come from a positional Hamming model.
// Counter width is reduced so saturation is reachable quickly.
module tb_ecc_encode_pipe;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [5:0]       out_parity;
  logic [CNT_W-1:0] word_count;
  logic             inject_en;
  logic [5:0]       inject_pos;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  int out_xfer_cnt = 0;
  logic [37:0] sb_q[$];

  ecc_encode_pipe #(.DATA_W(32), .PAR_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity(out_parity), .word_count(word_count),
    .inject_en(inject_en), .inject_pos(inject_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Data bit i sits at the i-th non-power-of-two Hamming position from 3; p[k] covers positions with bit k set.
  function automatic logic [37:0] enc_model(input logic [31:0] d, input logic ie, input logic [5:0] ip);
    logic [5:0] p;
    logic [37:0] cw;
    int pos;
    p = 6'd0;
    pos = 3;
    for (int i = 0; i < 32; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      for (int k = 0; k < 6; k++) begin
        if (d[i] && (((pos >> k) & 1) == 1)) p[k] = ~p[k];
      end
      pos++;
    end
    cw = {p, d};
`ifdef ERR_INJECT_EN
    if (ie && (ip < 6'd38)) cw[ip] = ~cw[ip];
`else
    if (ie && (ip == 6'd63)) cw = cw;
`endif
    return cw;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        out_xfer_cnt++;
        check_eq("sb_nonempty", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          logic [37:0] e;
          e = sb_q.pop_front();
          check_eq("sb_data", out_data, e[31:0]);
          check_eq("sb_parity", out_parity, e[37:32]);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(enc_model(in_data, inject_en, inject_pos));
    end
  end

  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_eq("accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", (sb_q.size() == 0 && !out_valid), 1'b1);
  endtask

  initial begin
    logic [37:0] e;
    logic [CNT_W-1:0] wc0;
    int x0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    inject_en = 1'b0; inject_pos = 6'd0;
    #3;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_parity", out_parity, 6'h00);
    check_eq("rst_word_count", word_count, 4'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Test 1: zero word, one-cycle latency
    out_ready = 1'b1;
    send_word(32'h0000_0000);
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_data", out_data, 32'h0);
    check_eq("t1_parity", out_parity, 6'h00);
    drain();
    check_eq("t1_count", word_count, 4'd1);

    // Test 2: known parity vectors
    send_word(32'h0000_0001);
    check_eq("t2_par_1", out_parity, 6'h03);
    send_word(32'h8000_0000);
    check_eq("t2_par_msb", out_parity, 6'h26);
    send_word(32'hFFFF_FFFF);
    check_eq("t2_par_ones", out_parity, 6'h18);
    drain();
    check_eq("t2_count", word_count, 4'd4);

    // Test 3: 8-word back-to-back stream
    wc0 = word_count;
    x0 = out_xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check_eq("t3_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("t3_xfers", out_xfer_cnt - x0, 8);
    check_eq("t3_count", word_count - wc0, 4'd8);
    check_eq("t3_empty", sb_q.size(), 0);

    // Test 4: back-pressure fills the skid register
    out_ready = 1'b0;
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    check_eq("t4_in_ready_full", in_ready, 1'b0);
    check_eq("t4_hold_data", out_data, 32'hAAAA_0001);
    in_valid = 1'b1;
    in_data  = 32'hCCCC_0003;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_still_full", in_ready, 1'b0);
    check_eq("t4_still_hold", out_data, 32'hAAAA_0001);
    e = enc_model(32'hAAAA_0001, 1'b0, 6'd0);
    check_eq("t4_hold_parity", out_parity, e[37:32]);
    out_ready = 1'b1;
    send_word(32'hCCCC_0003);
    drain();
    check_eq("t4_count", word_count, 4'd15);

    // Saturation of the counter
    for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + i);
    drain();
    check_eq("sat_count", word_count, 4'd15);

    // Test 5: asynchronous reset while FULL
    out_ready = 1'b0;
    send_word(32'hDDDD_0004);
    send_word(32'hEEEE_0005);
    check_eq("t5_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 1'b0);
    check_eq("t5_rst_parity", out_parity, 6'h00);
    check_eq("t5_rst_data", out_data, 32'h0);
    check_eq("t5_rst_count", word_count, 4'd0);
    sb_q.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_ready_after", in_ready, 1'b1);
    check_eq("t5_valid_after", out_valid, 1'b0);
    out_ready = 1'b1;
    send_word(32'h1234_5678);
    e = enc_model(32'h1234_5678, 1'b0, 6'd0);
    check_eq("t5_new_data", out_data, e[31:0]);
    check_eq("t5_new_parity", out_parity, e[37:32]);
    drain();
    check_eq("t5_count", word_count, 4'd1);

    // Test 6: error injection (ignored in the default build)
    inject_en = 1'b1;
`ifdef ERR_INJECT_EN
    inject_pos = 6'd5;
    send_word(32'h0);
    check_eq("t6_inj5_data", out_data, 32'h0000_0020);
    check_eq("t6_inj5_par", out_parity, 6'h00);
    inject_pos = 6'd35;
    send_word(32'h0);
    check_eq("t6_inj35_data", out_data, 32'h0);
    check_eq("t6_inj35_par", out_parity, 6'h08);
    inject_pos = 6'd40;
    send_word(32'h0);
    check_eq("t6_inj40_data", out_data, 32'h0);
    check_eq("t6_inj40_par", out_parity, 6'h00);
`else
    inject_pos = 6'd5;
    send_word(32'h0);
    check_eq("t6_noinj_data", out_data, 32'h0);
    check_eq("t6_noinj_par", out_parity, 6'h00);
    inject_pos = 6'd35;
    send_word(32'h0);
    check_eq("t6_noinj35_par", out_parity, 6'h00);
`endif
    inject_en = 1'b0;
    drain();
`ifdef ERR_INJECT_EN
    check_eq("t6_count", word_count, 4'd4);
`else
    check_eq("t6_count", word_count, 4'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
